// File: rtl/regfile_writeback_if.sv
// ---------------------------------------------------------------------------
// regfile_writeback_if
//   Bundles the write-back stage's operand, handshake and write-port signals.
//
//   master : pipeline side (drives ALU/load results, pend_set and rs1/rs2;
//            observes ld_ready, busy/forward flags and the write port)
//   slave  : the write-back block itself
//
//   alu_valid/alu_rd/alu_val       single-cycle ALU result, no back-pressure
//   ld_valid/ld_ready/ld_rd/ld_val load result, valid/ready handshake
//   pend_set/pend_rd               an issued load now owns pend_rd
//   rs1/rs2                        decode-stage source indices
//   rsX_busy                       source awaits a load result
//   rsX_fwd/rsX_fwd_val            forwarding of the staged write
//   write_rd/rd/rd_val             register-file write port
// ---------------------------------------------------------------------------
interface regfile_writeback_if #(
    parameter int XLEN = 32
);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_val;

    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_val;

    logic            pend_set;
    logic [4:0]      pend_rd;

    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            rs1_fwd;
    logic            rs2_fwd;
    logic [XLEN-1:0] rs1_fwd_val;
    logic [XLEN-1:0] rs2_fwd_val;

    logic            write_rd;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_val;

    modport master (
        output alu_valid, alu_rd, alu_val,
        output ld_valid, ld_rd, ld_val,
        output pend_set, pend_rd,
        output rs1, rs2,
        input  ld_ready,
        input  rs1_busy, rs2_busy, rs1_fwd, rs2_fwd, rs1_fwd_val, rs2_fwd_val,
        input  write_rd, rd, rd_val
    );

    modport slave (
        input  alu_valid, alu_rd, alu_val,
        input  ld_valid, ld_rd, ld_val,
        input  pend_set, pend_rd,
        input  rs1, rs2,
        output ld_ready,
        output rs1_busy, rs2_busy, rs1_fwd, rs2_fwd, rs1_fwd_val, rs2_fwd_val,
        output write_rd, rd, rd_val
    );
endinterface

// File: rtl/regfile_writeback.sv
// ---------------------------------------------------------------------------
// regfile_writeback
//   Arbitrates the ALU result and a 2-entry load-result FIFO onto a single
//   registered register-file write port, tracks registers owned by in-flight
//   loads (pending vector) and forwards the staged write to decode.
//
//   clk      : single clock, rising edge
//   reset_n  : asynchronous, active-low reset
//   bus      : regfile_writeback_if.slave (ALU/load inputs, pend_set,
//              rs1/rs2 lookups, busy/forward outputs, write port)
//
//   Priority each cycle: ALU (rd!=0) > FIFO head > no write. The ALU never
//   stalls; a blocked FIFO head simply waits.
// ---------------------------------------------------------------------------
module regfile_writeback #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    regfile_writeback_if.slave bus
);
    localparam int DEPTH = 2;

    // Load FIFO: storage plus head pointer and occupancy.
    logic [4:0]      fifo_rd  [DEPTH];
    logic [XLEN-1:0] fifo_val [DEPTH];
    logic            head;
    logic [1:0]      count;

    logic [31:0]     pending;
    logic [31:0]     pending_next;

    // Staged write port.
    logic            write_rd_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] rd_val_q;

    logic            ld_ready;
    logic            enq;
    logic            alu_req;
    logic            sel_fifo;
    logic            wr_idx;

    // Readiness comes from the registered count only, so it has no
    // combinational path from the ALU side.
    assign ld_ready = (count < 2'd2);
    // A load to x0 completes the handshake but is never stored.
    assign enq      = bus.ld_valid && ld_ready && (bus.ld_rd != 5'd0);
    assign alu_req  = bus.alu_valid && (bus.alu_rd != 5'd0);
    assign sel_fifo = !alu_req && (count != 2'd0);
    // Tail slot is head + count (mod 2); only meaningful when count < 2.
    assign wr_idx   = head ^ count[0];

    // Clear on head selection first, then set, so a same-cycle set wins.
    always_comb begin
        pending_next = pending;
        if (sel_fifo)
            pending_next[fifo_rd[head]] = 1'b0;
        if (bus.pend_set && (bus.pend_rd != 5'd0))
            pending_next[bus.pend_rd] = 1'b1;
        pending_next[0] = 1'b0;
    end

    // NOTE: FIFO storage is deliberately not reset; count gates every read,
    // so stale slots are never observed and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_rd[wr_idx]  <= bus.ld_rd;
            fifo_val[wr_idx] <= bus.ld_val;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head       <= 1'b0;
            count      <= 2'd0;
            pending    <= '0;
            write_rd_q <= 1'b0;
            rd_q       <= 5'd0;
            rd_val_q   <= '0;
        end else begin
            // Simultaneous enqueue and dequeue leave count unchanged.
            count   <= count + {1'b0, enq} - {1'b0, sel_fifo};
            pending <= pending_next;
            if (sel_fifo)
                head <= ~head;

            write_rd_q <= alu_req || sel_fifo;
            // rd/rd_val hold their previous values when nothing is selected.
            if (alu_req) begin
                rd_q     <= bus.alu_rd;
                rd_val_q <= bus.alu_val;
            end else if (sel_fifo) begin
                rd_q     <= fifo_rd[head];
                rd_val_q <= fifo_val[head];
            end
        end
    end

    assign bus.ld_ready    = ld_ready;
    assign bus.write_rd    = write_rd_q;
    assign bus.rd          = rd_q;
    assign bus.rd_val      = rd_val_q;

    assign bus.rs1_busy    = pending[bus.rs1];
    assign bus.rs2_busy    = pending[bus.rs2];
    assign bus.rs1_fwd     = write_rd_q && (rd_q == bus.rs1) && (bus.rs1 != 5'd0);
    assign bus.rs2_fwd     = write_rd_q && (rd_q == bus.rs2) && (bus.rs2 != 5'd0);
    assign bus.rs1_fwd_val = rd_val_q;
    assign bus.rs2_fwd_val = rd_val_q;
endmodule
